// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and encodings for the 5-stage RISC-V core.
package riscv_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       ALUSrc;
    logic [2:0] ALUControl;
  } ctrl_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage ALU operand; the M-stage producer wins over W.
module fwd_sel
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    // x0 is never forwarded: it reads as zero no matter who writes it.
    if ((rs_e_i != '0) && reg_write_m_i && (rs_e_i == rd_m_i)) begin
      fwd_o = FWD_MEM;
    end else if ((rs_e_i != '0) && reg_write_w_i && (rs_e_i == rd_w_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control and hazard unit: carries the control bundle D->E->M->W,
// detects load-use and taken branch/jump hazards, and selects ALU forwarding.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        CtrlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroE,
  output logic [9:0]        CtrlE,
  output logic [9:0]        CtrlM,
  output logic [9:0]        CtrlW,
  output logic [REG_AW-1:0] RdM,
  output logic [REG_AW-1:0] RdW,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_e_q, ctrl_e_d;
  ctrl_t             ctrl_m_q;
  ctrl_t             ctrl_w_q;
  logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
  logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
  logic [REG_AW-1:0] rd_e_q, rd_e_d;
  logic [REG_AW-1:0] rd_m_q;
  logic [REG_AW-1:0] rd_w_q;
  logic              lw_stall;
  logic              pc_src;
  logic              flush_e;

  assign ctrl_d = ctrl_t'(CtrlD);

  // A load in E whose result is needed by D cannot be forwarded in time.
  assign lw_stall = (ctrl_e_q.ResultSrc == RES_MEM) && (rd_e_q != '0) &&
                    ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
  assign pc_src   = (ctrl_e_q.Branch & ZeroE) | ctrl_e_q.Jump;
  assign flush_e  = lw_stall | pc_src;

  always_comb begin
    ctrl_e_d = ctrl_d;
    rs1_e_d  = Rs1D;
    rs2_e_d  = Rs2D;
    rd_e_d   = RdD;
    if (flush_e) begin
      ctrl_e_d = '0;
      rs1_e_d  = '0;
      rs2_e_d  = '0;
      rd_e_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_e_q <= '0;
      rs1_e_q  <= '0;
      rs2_e_q  <= '0;
      rd_e_q   <= '0;
      ctrl_m_q <= '0;
      rd_m_q   <= '0;
      ctrl_w_q <= '0;
      rd_w_q   <= '0;
    end else begin
      ctrl_e_q <= ctrl_e_d;
      rs1_e_q  <= rs1_e_d;
      rs2_e_q  <= rs2_e_d;
      rd_e_q   <= rd_e_d;
      ctrl_m_q <= ctrl_e_q;
      rd_m_q   <= rd_e_q;
      ctrl_w_q <= ctrl_m_q;
      rd_w_q   <= rd_m_q;
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i        (rs1_e_q),
    .rd_m_i        (rd_m_q),
    .reg_write_m_i (ctrl_m_q.RegWrite),
    .rd_w_i        (rd_w_q),
    .reg_write_w_i (ctrl_w_q.RegWrite),
    .fwd_o         (ForwardAE)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i        (rs2_e_q),
    .rd_m_i        (rd_m_q),
    .reg_write_m_i (ctrl_m_q.RegWrite),
    .rd_w_i        (rd_w_q),
    .reg_write_w_i (ctrl_w_q.RegWrite),
    .fwd_o         (ForwardBE)
  );

  assign CtrlE  = ctrl_e_q;
  assign CtrlM  = ctrl_m_q;
  assign CtrlW  = ctrl_w_q;
  assign RdM    = rd_m_q;
  assign RdW    = rd_w_q;
  assign PCSrcE = pc_src;
  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = pc_src;
  assign FlushE = flush_e;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a history-of-instructions model predicts every cycle's
// outputs into a queue; a monitor pops and compares once per cycle.
module tb_pipe_ctrl;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic [9:0] ctrl;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  typedef struct packed {
    logic [9:0] ctrl_e;
    logic [9:0] ctrl_m;
    logic [9:0] ctrl_w;
    logic [4:0] rd_m;
    logic [4:0] rd_w;
    logic       pcsrc;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
  } obs_t;

  localparam int OBS_W = $bits(obs_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]        CtrlD = '0;
  logic [REG_AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic              ZeroE = 1'b0;
  logic [9:0]        CtrlE, CtrlM, CtrlW;
  logic [REG_AW-1:0] RdM, RdW;
  logic              PCSrcE, StallF, StallD, FlushD, FlushE;
  logic [1:0]        ForwardAE, ForwardBE;

  pipe_ctrl #(.REG_AW(REG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .CtrlD(CtrlD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .ZeroE(ZeroE), .CtrlE(CtrlE), .CtrlM(CtrlM), .CtrlW(CtrlW),
    .RdM(RdM), .RdW(RdW), .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
  );

  // ---------------- reference model ----------------
  // pipe[0] = instruction in E, pipe[1] = in M, pipe[2] = in W (zero = bubble).
  instr_t pipe [3];
  logic [OBS_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic instr_t mk(input logic rw, input logic [1:0] res, input logic mw,
                                input logic j, input logic b, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd);
    instr_t t;
    t.ctrl = {rw, res, mw, j, b, 1'b1, 3'b010};
    t.rs1  = rs1;
    t.rs2  = rs2;
    t.rd   = rd;
    return t;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs != 0 && pipe[1].ctrl[9] && rs == pipe[1].rd) return 2'b10;
    if (rs != 0 && pipe[2].ctrl[9] && rs == pipe[2].rd) return 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t predict(input instr_t d, input logic z);
    obs_t   o;
    logic   load_use;
    logic   taken;
    load_use = (pipe[0].ctrl[8:7] == 2'b01) && (pipe[0].rd != 0) &&
               ((pipe[0].rd == d.rs1) || (pipe[0].rd == d.rs2));
    taken    = (pipe[0].ctrl[4] && z) || pipe[0].ctrl[5];
    o.ctrl_e  = pipe[0].ctrl;
    o.ctrl_m  = pipe[1].ctrl;
    o.ctrl_w  = pipe[2].ctrl;
    o.rd_m    = pipe[1].rd;
    o.rd_w    = pipe[2].rd;
    o.pcsrc   = taken;
    o.stall_f = load_use;
    o.stall_d = load_use;
    o.flush_d = taken;
    o.flush_e = load_use || taken;
    o.fwd_a   = model_fwd(pipe[0].rs1);
    o.fwd_b   = model_fwd(pipe[0].rs2);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input instr_t d, input logic z, input logic rst,
                      output logic stall, output logic flush);
    obs_t e;
    @(negedge clk);
    reset_n = rst;
    CtrlD = d.ctrl; Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; ZeroE = z;
    if (!rst) pipe = '{default: '0};
    e = predict(d, z);
    exp_q.push_back(e);
    stall = e.stall_f;
    flush = e.flush_d;
    if (rst) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e.flush_e ? instr_t'('0) : d;
    end
  endtask

  // Mimics the external F/D register: re-present while stalled, nop after a flush.
  task automatic issue(input instr_t d, input logic z, output int n_stall);
    logic st, fl;
    instr_t nop;
    nop = '0;
    n_stall = 0;
    step(d, z, 1'b1, st, fl);
    while (st && n_stall < 4) begin
      n_stall++;
      step(d, 1'b0, 1'b1, st, fl);
    end
    if (fl) step(nop, 1'b0, 1'b1, st, fl);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = obs_t'(exp_q.pop_front());
        a = {CtrlE, CtrlM, CtrlW, RdM, RdW, PCSrcE, StallF, StallD, FlushD, FlushE,
             ForwardAE, ForwardBE};
        check("CtrlE", 32'(a.ctrl_e), 32'(e.ctrl_e));
        check("CtrlM", 32'(a.ctrl_m), 32'(e.ctrl_m));
        check("CtrlW", 32'(a.ctrl_w), 32'(e.ctrl_w));
        check("RdM_RdW", 32'({a.rd_m, a.rd_w}), 32'({e.rd_m, e.rd_w}));
        check("PCSrcE", 32'(a.pcsrc), 32'(e.pcsrc));
        check("StallF_StallD", 32'({a.stall_f, a.stall_d}), 32'({e.stall_f, e.stall_d}));
        check("FlushD_FlushE", 32'({a.flush_d, a.flush_e}), 32'({e.flush_d, e.flush_e}));
        check("ForwardAE", 32'(a.fwd_a), 32'(e.fwd_a));
        check("ForwardBE", 32'(a.fwd_b), 32'(e.fwd_b));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t nop, lw3, lw5, use5, w7, nw7, use7, lw0, use0, beq, jal, r;
    logic st, fl;
    int ns;
    nop  = '0;
    lw3  = mk(1, 2'b01, 0, 0, 0, 5'd1, 5'd0, 5'd3);
    lw5  = mk(1, 2'b01, 0, 0, 0, 5'd2, 5'd0, 5'd5);
    use5 = mk(1, 2'b00, 0, 0, 0, 5'd5, 5'd6, 5'd8);
    w7   = mk(1, 2'b00, 0, 0, 0, 5'd1, 5'd2, 5'd7);
    nw7  = mk(0, 2'b00, 1, 0, 0, 5'd1, 5'd2, 5'd7);
    use7 = mk(1, 2'b00, 0, 0, 0, 5'd3, 5'd7, 5'd9);
    lw0  = mk(1, 2'b01, 0, 0, 0, 5'd1, 5'd0, 5'd0);
    use0 = mk(1, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd4);
    beq  = mk(0, 2'b00, 0, 0, 1, 5'd1, 5'd2, 5'd0);
    jal  = mk(1, 2'b10, 0, 1, 0, 5'd0, 5'd0, 5'd1);
    pipe = '{default: '0};

    // Reset held with a load on the D inputs: everything must stay at bubble.
    repeat (3) step(lw3, 1'b0, 1'b0, st, fl);
    step(lw3, 1'b0, 1'b1, st, fl);
    repeat (3) step(nop, 1'b0, 1'b1, st, fl);
    #3 check("reset_release_CtrlW_ResultSrc", 32'(CtrlW[8:7]), 32'd1);

    // Load-use: exactly one stall, then W forwarding after the bubble.
    issue(lw5, 1'b0, ns);
    issue(use5, 1'b0, ns);
    check("load_use_stall_cycles", 32'(ns), 32'd1);
    issue(nop, 1'b0, ns);
    issue(nop, 1'b0, ns);

    // Forward priority: M beats W; without RegWrite in M, W is chosen.
    issue(w7, 1'b0, ns);
    issue(w7, 1'b0, ns);
    issue(use7, 1'b0, ns);
    issue(nop, 1'b0, ns);
    issue(w7, 1'b0, ns);
    issue(nw7, 1'b0, ns);
    issue(use7, 1'b0, ns);
    issue(nop, 1'b0, ns);

    // x0 destination neither stalls nor forwards.
    issue(lw0, 1'b0, ns);
    issue(use0, 1'b0, ns);
    check("x0_no_stall", 32'(ns), 32'd0);
    issue(nop, 1'b0, ns);

    // Branch taken / not taken, and jal regardless of ZeroE.
    issue(beq, 1'b0, ns);
    issue(nop, 1'b1, ns);
    issue(beq, 1'b0, ns);
    issue(nop, 1'b0, ns);
    issue(jal, 1'b0, ns);
    issue(nop, 1'b0, ns);
    issue(nop, 1'b0, ns);

    // Asynchronous reset between edges while a load-use stall is active.
    issue(lw5, 1'b0, ns);
    @(negedge clk);
    CtrlD = use5.ctrl; Rs1D = use5.rs1; Rs2D = use5.rs2; RdD = use5.rd; ZeroE = 1'b0;
    #3 check("midstream_stall_before_reset", 32'({StallF, FlushE}), 32'b11);
    reset_n = 1'b0;
    #1;
    check("midstream_ctrl_zero", 32'({CtrlE, CtrlM}), 32'd0);
    check("midstream_ctrlw_rd_zero", 32'({CtrlW, RdM, RdW}), 32'd0);
    check("midstream_strobes_zero",
          32'({PCSrcE, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}), 32'd0);
    pipe = '{default: '0};
    step(nop, 1'b0, 1'b0, st, fl);
    step(nop, 1'b0, 1'b1, st, fl);

    // Randomized instruction stream with a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] res;
      res = 2'($urandom_range(0, 2));
      r = mk(1'($urandom_range(0, 1)), res, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      r.ctrl[3:0] = 4'($urandom_range(0, 15));
      issue(r, 1'($urandom_range(0, 1)), ns);
    end

    repeat (2) @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
